// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: 2-bit predictor counter
// encodings, the counter reset value and the pc-to-index width helper.
package branch_resolver_pkg;

  localparam logic [1:0] BHT_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] BHT_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] BHT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] BHT_ST  = 2'b11;  // strongly taken

  // Counters come out of reset weakly not taken, so the first taken
  // resolution flips the prediction.
  localparam logic [1:0] BHT_RESET = BHT_WNT;

  // Number of pc bits (above the word offset) used to index the table.
  function automatic int bht_index_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_resolver_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational lookup port and one registered update port.
module branch_history_table
  import branch_resolver_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IW          = bht_index_w(BHT_ENTRIES)
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] lookup_idx,
  output logic          lookup_taken,
  input  logic          update_en,
  input  logic [IW-1:0] update_idx,
  input  logic          update_taken
);

  logic [1:0] counters [BHT_ENTRIES];

  // Saturating step of a 2-bit counter toward taken or not taken.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BHT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BHT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

  // Lookup reads the registered counter, so a same-cycle update is not visible.
  assign lookup_taken = counters[lookup_idx][1];

  // Counter array: reset to weakly not taken, trained by resolved branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        counters[i] <= BHT_RESET;
      end
    end else if (update_en) begin
      counters[update_idx] <= sat_step(counters[update_idx], update_taken);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: carries control-flow instructions through E, M and W,
// resolves their targets and drives the fetch redirect interface. The
// oldest redirecting stage suppresses younger ones, so at most one
// redirect is active per cycle. Owns the branch history table.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_valid,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_immediate,
  input  logic        d_condition_branch,
  input  logic        d_taken,
  input  logic [31:0] d_predict_pc,
  input  logic        d_is_jalr,
  input  logic        d_is_ret,
  input  logic [31:0] e_rs1_value,
  input  logic        e_branch_cond,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic        jalr,
  output logic [31:0] stage_e_pc,
  output logic        mispredict,
  output logic [31:0] stage_m_pc,
  output logic        ret,
  output logic [31:0] stage_w_pc,
  output logic        flush_decode
);

  localparam int IW = bht_index_w(BHT_ENTRIES);

  // E stage (_p0) registers
  logic          vld_p0;
  logic [31:0]   pc_p0;
  logic [31:0]   imm_p0;
  logic          cond_p0;
  logic [31:0]   predict_pc_p0;
  logic          is_jalr_p0;
  logic          is_ret_p0;

  // M stage (_p1) registers
  logic          vld_p1;
  logic [IW-1:0] bht_idx_p1;
  logic          cond_p1;
  logic [31:0]   predict_pc_p1;
  logic          is_ret_p1;
  logic          actual_taken_p1;
  logic [31:0]   target_p1;

  // W stage (_p2) registers
  logic          vld_p2;
  logic          is_ret_p2;
  logic [31:0]   target_p2;

  logic [31:0]   jalr_sum_p0;
  logic [31:0]   br_next_p0;
  logic [31:0]   target_p0;
  logic          actual_taken_p0;
  logic          bht_update;

  // ---- E stage: resolve targets (addresses wrap mod 2^32) ----
  assign jalr_sum_p0     = e_rs1_value + imm_p0;
  assign br_next_p0      = e_branch_cond ? (pc_p0 + imm_p0) : (pc_p0 + 32'd4);
  assign target_p0       = cond_p0 ? br_next_p0 : {jalr_sum_p0[31:1], 1'b0};
  assign actual_taken_p0 = cond_p0 & e_branch_cond;

  // Redirects, oldest first; each younger one is masked by the older ones.
  assign ret          = ~stall & vld_p2 & is_ret_p2;
  assign mispredict   = ~stall & vld_p1 & cond_p1 & (target_p1 != predict_pc_p1) & ~ret;
  assign jalr         = ~stall & vld_p0 & is_jalr_p0 & ~mispredict & ~ret;
  assign flush_decode = jalr | mispredict | ret;

  // Pc outputs read as zero while the stage holds no instruction.
  assign stage_e_pc = vld_p0 ? target_p0 : 32'h0;
  assign stage_m_pc = vld_p1 ? target_p1 : 32'h0;
  assign stage_w_pc = vld_p2 ? target_p2 : 32'h0;

  // Train only on a branch that actually leaves M and is not killed by a return.
  assign bht_update = ~stall & vld_p1 & cond_p1 & ~ret;

  // Stage valids: advance when not stalled, squashing younger stages on redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= d_valid & ~flush_decode;
      vld_p1 <= vld_p0 & ~mispredict & ~ret;
      vld_p2 <= vld_p1 & ~ret;
    end
  end

  // Stage payloads: qualified by the valids above, so no reset needed.
  always_ff @(posedge clk) begin
    if (!stall) begin
      // ---- D -> E ----
      pc_p0           <= d_pc;
      imm_p0          <= d_immediate;
      cond_p0         <= d_condition_branch;
      predict_pc_p0   <= d_predict_pc;
      is_jalr_p0      <= d_is_jalr;
      is_ret_p0       <= d_is_ret;
      // ---- E -> M ----
      bht_idx_p1      <= pc_p0[IW+1:2];
      cond_p1         <= cond_p0;
      predict_pc_p1   <= predict_pc_p0;
      is_ret_p1       <= is_ret_p0;
      actual_taken_p1 <= actual_taken_p0;
      target_p1       <= target_p0;
      // ---- M -> W ----
      is_ret_p2       <= is_ret_p1;
      target_p2       <= target_p1;
    end
  end

  branch_history_table #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .IW          (IW)
  ) u_bht (
    .clk          (clk),
    .reset        (reset),
    .lookup_idx   (lookup_pc[IW+1:2]),
    .lookup_taken (lookup_taken),
    .update_en    (bht_update),
    .update_idx   (bht_idx_p1),
    .update_taken (actual_taken_p1)
  );

  // Fetch's own prediction and the untouched pc bits are not needed here.
  logic unused_ok;
  assign unused_ok = ^{d_taken, lookup_pc[31:IW+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus queues the expected
// redirect (kind and target pc); a negedge monitor pops and compares
// whenever any redirect is presented.
module tb_branch_resolver;

  localparam logic [1:0] K_JALR = 2'd1;
  localparam logic [1:0] K_MISP = 2'd2;
  localparam logic [1:0] K_RET  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_immediate;
  logic        d_condition_branch;
  logic        d_taken;
  logic [31:0] d_predict_pc;
  logic        d_is_jalr;
  logic        d_is_ret;
  logic [31:0] e_rs1_value;
  logic        e_branch_cond;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        jalr;
  logic [31:0] stage_e_pc;
  logic        mispredict;
  logic [31:0] stage_m_pc;
  logic        ret;
  logic [31:0] stage_w_pc;
  logic        flush_decode;

  int   checks;
  int   failures;
  exp_t exp_q[$];

  exp_t        mon_exp;
  logic [1:0]  mon_kind;
  logic [31:0] mon_pc;
  int          mon_n;

  branch_resolver #(.BHT_ENTRIES(64)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .d_valid            (d_valid),
    .d_pc               (d_pc),
    .d_immediate        (d_immediate),
    .d_condition_branch (d_condition_branch),
    .d_taken            (d_taken),
    .d_predict_pc       (d_predict_pc),
    .d_is_jalr          (d_is_jalr),
    .d_is_ret           (d_is_ret),
    .e_rs1_value        (e_rs1_value),
    .e_branch_cond      (e_branch_cond),
    .lookup_pc          (lookup_pc),
    .lookup_taken       (lookup_taken),
    .jalr               (jalr),
    .stage_e_pc         (stage_e_pc),
    .mispredict         (mispredict),
    .stage_m_pc         (stage_m_pc),
    .ret                (ret),
    .stage_w_pc         (stage_w_pc),
    .flush_decode       (flush_decode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp);
    lookup_pc = pc;
    #1;
    chk1(name, lookup_taken, exp);
  endtask

  task automatic drive_d(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pred,
                         input logic cond, input logic is_j, input logic is_r);
    d_valid            = 1'b1;
    d_pc               = pc;
    d_immediate        = imm;
    d_predict_pc       = pred;
    d_condition_branch = cond;
    d_is_jalr          = is_j;
    d_is_ret           = is_r;
    d_taken            = (pred != pc + 32'd4);
  endtask

  task automatic clear_d();
    d_valid            = 1'b0;
    d_condition_branch = 1'b0;
    d_is_jalr          = 1'b0;
    d_is_ret           = 1'b0;
  endtask

  // One conditional branch: two cycles in D/E, leaves it sitting in M.
  task automatic br(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pred,
                    input logic taken);
    drive_d(pc, imm, pred, 1'b1, 1'b0, 1'b0);
    tick();
    clear_d();
    e_branch_cond = taken;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_jalr"}, jalr, 1'b0);
    chk1({tag, "_mispredict"}, mispredict, 1'b0);
    chk1({tag, "_ret"}, ret, 1'b0);
    chk1({tag, "_flush"}, flush_decode, 1'b0);
    chk32({tag, "_stage_e_pc"}, stage_e_pc, 32'h0);
    chk32({tag, "_stage_m_pc"}, stage_m_pc, 32'h0);
    chk32({tag, "_stage_w_pc"}, stage_w_pc, 32'h0);
  endtask

  // Monitor: every presented redirect must match the next queued expectation.
  always @(negedge clk) begin
    mon_n = int'(jalr) + int'(mispredict) + int'(ret);
    if (mon_n != 0) begin
      mon_kind = ret ? K_RET : (mispredict ? K_MISP : K_JALR);
      mon_pc   = ret ? stage_w_pc : (mispredict ? stage_m_pc : stage_e_pc);
      checks++;
      if (mon_n != 1 || !flush_decode) begin
        failures++;
        $display("FAIL redirect_shape actual=count%0d/flush%b required=count1/flush1", mon_n, flush_decode);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_redirect actual=kind%0d pc=%h required=none", mon_kind, mon_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp.kind != mon_kind || mon_exp.pc != mon_pc) begin
          failures++;
          $display("FAIL redirect actual=kind%0d pc=%h required=kind%0d pc=%h",
                   mon_kind, mon_pc, mon_exp.kind, mon_exp.pc);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    clear_d();
    d_pc          = 32'h0;
    d_immediate   = 32'h0;
    d_predict_pc  = 32'h0;
    d_taken       = 1'b0;
    e_rs1_value   = 32'h0;
    e_branch_cond = 1'b0;
    lookup_pc     = 32'h0;

    // Reset state
    @(negedge clk);
    chk_idle("reset");
    look("reset_lookup_0", 32'h0, 1'b0);
    look("reset_lookup_1fc", 32'h1FC, 1'b0);
    tick();
    reset = 1'b0;

    // beq 0x100 +0x20 predicted not taken, actually taken
    exp_q.push_back('{K_MISP, 32'h120});
    drive_d(32'h100, 32'h20, 32'h104, 1'b1, 1'b0, 1'b0);
    tick();
    clear_d();
    e_branch_cond = 1'b1;
    tick();
    tick();
    @(negedge clk);
    look("bht_after_beq", 32'h100, 1'b1);

    // jalr with odd sum: low bit cleared
    exp_q.push_back('{K_JALR, 32'h2006});
    drive_d(32'h200, 32'h4, 32'h204, 1'b0, 1'b1, 1'b0);
    tick();
    clear_d();
    e_rs1_value = 32'h2003;
    tick();
    tick();

    // Reset while a jalr sits in E: redirect must drop at once
    drive_d(32'h210, 32'h0, 32'h214, 1'b0, 1'b1, 1'b0);
    tick();
    clear_d();
    e_rs1_value = 32'h3000;
    reset = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    look("midreset_lookup_0", 32'h0, 1'b0);
    look("midreset_lookup_1fc", 32'h1FC, 1'b0);
    look("midreset_bht_cleared", 32'h100, 1'b0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // ret in W, mispredicting branch in M, jalr in E: only ret fires
    exp_q.push_back('{K_RET, 32'h400});
    drive_d(32'h300, 32'h0, 32'h304, 1'b0, 1'b0, 1'b1);
    tick();
    e_rs1_value = 32'h400;
    drive_d(32'h140, 32'h40, 32'h144, 1'b1, 1'b0, 1'b0);
    tick();
    e_branch_cond = 1'b1;
    e_rs1_value   = 32'h5000;
    drive_d(32'h180, 32'h0, 32'h184, 1'b0, 1'b1, 1'b0);
    tick();
    clear_d();
    @(negedge clk);
    chk1("ret_blocks_mispredict", mispredict, 1'b0);
    chk1("ret_blocks_jalr", jalr, 1'b0);
    chk32("ret_target", stage_w_pc, 32'h400);
    repeat (3) tick();
    @(negedge clk);
    look("bht_no_update_on_ret", 32'h140, 1'b0);

    // Stall for 3 cycles with a mispredicting branch in M
    exp_q.push_back('{K_MISP, 32'h284});
    drive_d(32'h280, 32'hFFFF_FFF8, 32'h278, 1'b1, 1'b0, 1'b0);
    tick();
    clear_d();
    e_branch_cond = 1'b0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall_mispredict", mispredict, 1'b0);
      chk1("stall_flush", flush_decode, 1'b0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    chk1("stall_release_mispredict", mispredict, 1'b1);
    tick();
    tick();

    // Saturation: 5 taken, then not-taken steps, then floor and recover
    repeat (5) br(32'h3C0, 32'h10, 32'h3D0, 1'b1);
    tick();
    @(negedge clk);
    look("sat_after_5_taken", 32'h3C0, 1'b1);
    br(32'h3C0, 32'h10, 32'h3C4, 1'b0);
    tick();
    @(negedge clk);
    look("sat_after_1_not_taken", 32'h3C0, 1'b1);
    br(32'h3C0, 32'h10, 32'h3C4, 1'b0);
    tick();
    @(negedge clk);
    look("sat_after_2_not_taken", 32'h3C0, 1'b0);
    br(32'h3C0, 32'h10, 32'h3C4, 1'b0);
    br(32'h3C0, 32'h10, 32'h3C4, 1'b0);
    br(32'h3C0, 32'h10, 32'h3D0, 1'b1);
    tick();
    @(negedge clk);
    look("sat_floor_then_taken", 32'h3C0, 1'b0);

    repeat (3) tick();
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
